// File: rtl/carregador_ram_pkg.sv
// Shared definitions for the SAP RAM loader: widths, loader FSM states and a
// small helper that classifies the states in which a load is in flight.
package carregador_ram_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } loadState_e;

  function automatic logic isBusy(input loadState_e s);
    return (s == ACCEPT) || (s == STROBE) || (s == HOLD);
  endfunction

endpackage

// File: rtl/carregador_ram_mar_reg.sv
// Memory address register: WIDTH-bit register with asynchronous active-high
// reset and a synchronous load enable.
module mar_reg
  import carregador_ram_pkg::*;
#(
  parameter int WIDTH = SAP_ADDR_W
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] addr_q;

  // Capture the address when load is asserted, otherwise keep it.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q <= '0;
    end else if (load_i) begin
      addr_q <= d_i;
    end
  end

  assign q_o = addr_q;

endmodule

// File: rtl/carregador_ram.sv
// Upstream stage of the 16x8 SAP RAM. In run mode it is the MAR; in program
// mode it takes a byte stream (valid/ready) and writes it to addresses
// 0..DEPTH-1 with a registered one-cycle write strobe that rises one cycle
// after address and data have settled.
// Optional feature: define CARREGADOR_CHECKSUM_EN to accumulate a running
// mod-2**DATA_W sum of the written bytes on load_checksum (0 otherwise).
module carregador_ram
  import carregador_ram_pkg::*;
#(
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              programm_run,
  input  logic              MAR_IN,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] in_mar,
  output logic [DATA_W-1:0] ram_dip,
  output logic              wr_strobe,
  output logic              load_busy,
  output logic              load_done,
  output logic [DATA_W-1:0] load_checksum
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loadState_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] ramDip_q, ramDip_d;
  logic              loadDone_q, loadDone_d;
  logic              wrStrobe_q, wrStrobe_d;
  logic [ADDR_W-1:0] marQ;
  logic              startLoad;
  logic              acceptByte;

  // Only the low ADDR_W bits of the bus address the RAM; the rest is unused.
  logic unusedBusHi;
  assign unusedBusHi = ^bus_in[DATA_W-1:ADDR_W];

  mar_reg #(.WIDTH(ADDR_W)) u_mar (
    .clock_i (clock),
    .reset_i (reset),
    .load_i  (programm_run & MAR_IN),
    .d_i     (bus_in[ADDR_W-1:0]),
    .q_o     (marQ)
  );

  assign byte_ready = (state_q == ACCEPT) && !programm_run;
  assign acceptByte = byte_ready && byte_valid;
  assign startLoad  = !programm_run && load_start &&
                      ((state_q == IDLE) || (state_q == DONE));

  // Loader next-state logic: run mode aborts any load in flight, program
  // mode steps ACCEPT -> STROBE -> HOLD once per byte until the last address.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ramDip_d   = ramDip_q;
    loadDone_d = loadDone_q;
    wrStrobe_d = 1'b0;
    if (programm_run) begin
      if (isBusy(state_q)) begin
        state_d    = IDLE;
        loadDone_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (load_start) begin
            ptr_d      = '0;
            loadDone_d = 1'b0;
            state_d    = ACCEPT;
          end
        end
        ACCEPT: begin
          if (byte_valid) begin
            ramDip_d = byte_data;
            state_d  = STROBE;
          end
        end
        STROBE: begin
          wrStrobe_d = 1'b1;
          state_d    = HOLD;
        end
        HOLD: begin
          if (ptr_q == LAST_ADDR) begin
            loadDone_d = 1'b1;
            state_d    = DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = ACCEPT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Loader state, pointer, write data and strobe registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      ramDip_q   <= '0;
      loadDone_q <= 1'b0;
      wrStrobe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ramDip_q   <= ramDip_d;
      loadDone_q <= loadDone_d;
      wrStrobe_q <= wrStrobe_d;
    end
  end

`ifdef CARREGADOR_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Running sum of accepted bytes, restarted with every new load.
  always_comb begin
    checksum_d = checksum_q;
    if (startLoad) begin
      checksum_d = '0;
    end else if (acceptByte) begin
      checksum_d = checksum_q + byte_data;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign load_checksum = checksum_q;
`else
  logic unusedLoadCtl;
  assign unusedLoadCtl = startLoad ^ acceptByte;
  assign load_checksum = '0;
`endif

  // Run mode gates the strobe combinationally so an abort never leaves a
  // partial write pulse on the RAM.
  assign in_mar    = programm_run ? marQ : ptr_q;
  assign ram_dip   = ramDip_q;
  assign wr_strobe = wrStrobe_q & ~programm_run;
  assign load_busy = isBusy(state_q);
  assign load_done = loadDone_q;

endmodule
